// File: rtl/vend_controller.sv
// vend_controller: coin-operated vending transaction controller.
// Accumulates 5/10-unit credit, arbitrates selections against price,
// drives the dispenser and change hopper through req/ack handshakes.
// Optional build macro VEND_STOCK_COUNT_EN adds per-product stock counters,
// restock inputs and sold_out flags.
module vend_controller #(
    parameter int PRICE_A     = 15,
    parameter int PRICE_B     = 20,
    parameter int MAX_CREDIT  = 40,
    parameter int CREDIT_W    = 6,
    parameter int TIMEOUT_CYC = 1000
`ifdef VEND_STOCK_COUNT_EN
    ,
    parameter int STOCK_INIT  = 8
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_5,
    input  logic                coin_10,
    input  logic                sel_valid,
    input  logic                sel_id,
    input  logic                cancel,
    output logic                disp_req,
    output logic                disp_id,
    input  logic                disp_ack,
    output logic                chg_req,
    output logic                chg_coin,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject,
    output logic                sel_deny
`ifdef VEND_STOCK_COUNT_EN
    ,
    input  logic                restock,
    input  logic                restock_id,
    output logic [1:0]          sold_out
`endif
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CREDIT   = 2'd1;
    localparam logic [1:0] S_DISPENSE = 2'd2;
    localparam logic [1:0] S_CHANGE   = 2'd3;

    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [CREDIT_W-1:0] L_PRICE_A = CREDIT_W'(PRICE_A);
    localparam logic [CREDIT_W-1:0] L_PRICE_B = CREDIT_W'(PRICE_B);
    localparam logic [CREDIT_W-1:0] L_FIVE    = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] L_TEN     = CREDIT_W'(10);
    localparam logic [CREDIT_W:0]   L_MAX     = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [TMO_W-1:0]    L_TMO_END = TMO_W'(TIMEOUT_CYC - 1);

    logic [1:0]          r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_disp_req;
    logic                r_disp_id;
    logic                r_chg_req;
    logic                r_chg_coin;
    logic                r_coin_reject;
    logic                r_sel_deny;

    logic                w_coin_one;
    logic                w_coin_open;
    logic [CREDIT_W:0]   w_coin_val;
    logic                w_coin_ok;
    logic [CREDIT_W-1:0] w_coin_add;
    logic [CREDIT_W-1:0] w_price;
    logic                w_stock_ok;
    logic                w_sel_ok;
    logic                w_tmo_hit;
    logic [CREDIT_W-1:0] w_chg_val;
    logic [CREDIT_W-1:0] w_credit_after_chg;
    logic                w_disp_done;

    // Coin acceptance: exactly one coin, in a state that takes coins,
    // and room below the credit ceiling (judged on the pre-coin credit).
    always_comb begin
        w_coin_one  = coin_5 ^ coin_10;
        w_coin_open = (r_state == S_IDLE) || (r_state == S_CREDIT);
        w_coin_val  = '0;
        if (w_coin_one) begin
            w_coin_val = coin_10 ? {1'b0, L_TEN} : {1'b0, L_FIVE};
        end
        w_coin_ok  = w_coin_one && w_coin_open && (({1'b0, r_credit} + w_coin_val) <= L_MAX);
        w_coin_add = w_coin_ok ? w_coin_val[CREDIT_W-1:0] : '0;
    end

    // Selection arbitration; cancel outranks a same-cycle selection.
    always_comb begin
        w_price  = sel_id ? L_PRICE_B : L_PRICE_A;
        w_sel_ok = (r_state == S_CREDIT) && sel_valid && !cancel &&
                   (r_credit >= w_price) && w_stock_ok;
        w_tmo_hit = (r_tmo == L_TMO_END);
        w_chg_val = r_chg_coin ? L_TEN : L_FIVE;
        w_credit_after_chg = r_credit - w_chg_val;
        w_disp_done = (r_state == S_DISPENSE) && r_disp_req && disp_ack;
    end

    // Main transaction FSM, credit register, timeout and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_credit      <= '0;
            r_tmo         <= '0;
            r_disp_req    <= 1'b0;
            r_disp_id     <= 1'b0;
            r_chg_req     <= 1'b0;
            r_chg_coin    <= 1'b0;
            r_coin_reject <= 1'b0;
            r_sel_deny    <= 1'b0;
        end else begin
            r_coin_reject <= (coin_5 || coin_10) && !w_coin_ok;
            r_sel_deny    <= sel_valid && !w_sel_ok;
            case (r_state)
                S_IDLE: begin
                    r_tmo <= '0;
                    if (w_coin_ok) begin
                        r_credit <= r_credit + w_coin_add;
                        r_state  <= S_CREDIT;
                    end
                end
                S_CREDIT: begin
                    if (cancel) begin
                        r_credit <= r_credit + w_coin_add;
                        r_tmo    <= '0;
                        r_state  <= S_CHANGE;
                    end else if (w_sel_ok) begin
                        r_credit   <= r_credit - w_price + w_coin_add;
                        r_disp_req <= 1'b1;
                        r_disp_id  <= sel_id;
                        r_tmo      <= '0;
                        r_state    <= S_DISPENSE;
                    end else if (sel_valid || w_coin_ok) begin
                        r_credit <= r_credit + w_coin_add;
                        r_tmo    <= '0;
                    end else if (w_tmo_hit) begin
                        r_tmo   <= '0;
                        r_state <= S_CHANGE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_DISPENSE: begin
                    if (w_disp_done) begin
                        r_disp_req <= 1'b0;
                        r_disp_id  <= 1'b0;
                        r_state    <= (r_credit == '0) ? S_IDLE : S_CHANGE;
                    end
                end
                default: begin
                    if (r_chg_req) begin
                        if (chg_ack) begin
                            r_chg_req  <= 1'b0;
                            r_chg_coin <= 1'b0;
                            r_credit   <= w_credit_after_chg;
                            if (w_credit_after_chg == '0) begin
                                r_state <= S_IDLE;
                            end
                        end
                    end else if (r_credit == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_chg_req  <= 1'b1;
                        r_chg_coin <= (r_credit >= L_TEN);
                    end
                end
            endcase
        end
    end

`ifdef VEND_STOCK_COUNT_EN
    logic [3:0] r_stock [2];
    logic [1:0] w_sold_out;

    // Sold-out flags and the stock gate on selection.
    always_comb begin
        w_sold_out[0] = (r_stock[0] == 4'd0);
        w_sold_out[1] = (r_stock[1] == 4'd0);
        w_stock_ok    = !w_sold_out[sel_id];
    end

    // Per-product stock: reload on reset or restock, count down on each completed dispense.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stock[0] <= 4'(STOCK_INIT);
            r_stock[1] <= 4'(STOCK_INIT);
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (restock && (restock_id == 1'(i))) begin
                    r_stock[i] <= 4'(STOCK_INIT);
                end else if (w_disp_done && (r_disp_id == 1'(i)) && (r_stock[i] != 4'd0)) begin
                    r_stock[i] <= r_stock[i] - 4'd1;
                end
            end
        end
    end

    assign sold_out = w_sold_out;
`else
    assign w_stock_ok = 1'b1;
`endif

    assign disp_req    = r_disp_req;
    assign disp_id     = r_disp_id;
    assign chg_req     = r_chg_req;
    assign chg_coin    = r_chg_coin;
    assign credit      = r_credit;
    assign busy        = (r_state == S_DISPENSE) || (r_state == S_CHANGE);
    assign coin_reject = r_coin_reject;
    assign sel_deny    = r_sel_deny;

endmodule

// File: tb/tb_vend_controller.sv
// Directed self-checking bench for vend_controller.
// Inputs change 1 time unit after a rising edge; outputs are read at the same point.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_5, coin_10, sel_valid, sel_id, cancel, disp_ack, chg_ack;
    logic       disp_req, disp_id, chg_req, chg_coin, busy, coin_reject, sel_deny;
    logic [5:0] credit;
`ifdef VEND_STOCK_COUNT_EN
    logic       restock, restock_id;
    logic [1:0] sold_out;
`endif

    int checkCount = 0;
    int passCount  = 0;

    localparam int TMO = 32;

    vend_controller #(
        .TIMEOUT_CYC(TMO)
`ifdef VEND_STOCK_COUNT_EN
        ,
        .STOCK_INIT(1)
`endif
    ) dut (
        .clk(clk), .rst(rst), .coin_5(coin_5), .coin_10(coin_10),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
        .disp_req(disp_req), .disp_id(disp_id), .disp_ack(disp_ack),
        .chg_req(chg_req), .chg_coin(chg_coin), .chg_ack(chg_ack),
        .credit(credit), .busy(busy), .coin_reject(coin_reject), .sel_deny(sel_deny)
`ifdef VEND_STOCK_COUNT_EN
        ,
        .restock(restock), .restock_id(restock_id), .sold_out(sold_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic c5, input logic c10, input logic sv, input logic sid,
                                 input logic cn, input logic da, input logic ca);
        coin_5 = c5; coin_10 = c10; sel_valid = sv; sel_id = sid;
        cancel = cn; disp_ack = da; chg_ack = ca;
        @(posedge clk); #1;
        coin_5 = 0; coin_10 = 0; sel_valid = 0; sel_id = 0;
        cancel = 0; disp_ack = 0; chg_ack = 0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic refill();
`ifdef VEND_STOCK_COUNT_EN
        for (int i = 0; i < 2; i++) begin
            restock = 1'b1; restock_id = 1'(i);
            @(posedge clk); #1;
            restock = 1'b0; restock_id = 1'b0;
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        coin_5 = 0; coin_10 = 0; sel_valid = 0; sel_id = 0;
        cancel = 0; disp_ack = 0; chg_ack = 0;
`ifdef VEND_STOCK_COUNT_EN
        restock = 0; restock_id = 0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("rst_credit", credit, 0);
        checkOutput("rst_disp_req", disp_req, 0);
        checkOutput("rst_chg_req", chg_req, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_reject", coin_reject, 0);
        checkOutput("rst_deny", sel_deny, 0);

        // Exact payment for A, no change.
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0);
            checkOutput("s1_credit", credit, 5 * i);
        end
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("s1_disp_req", disp_req, 1);
        checkOutput("s1_disp_id", disp_id, 0);
        checkOutput("s1_credit_after_sel", credit, 0);
        checkOutput("s1_busy", busy, 1);
        idleCycles(2);
        checkOutput("s1_req_held", disp_req, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("s1_req_drop", disp_req, 0);
        checkOutput("s1_idle", busy, 0);
        idleCycles(1);
        checkOutput("s1_no_chg", chg_req, 0);

        // 20 for A, one 5-unit change coin.
        refill();
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("s2_credit", credit, 20);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("s2_disp_req", disp_req, 1);
        checkOutput("s2_credit_left", credit, 5);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("s2_change_state", busy, 1);
        idleCycles(1);
        checkOutput("s2_chg_req", chg_req, 1);
        checkOutput("s2_chg_coin", chg_coin, 0);
        idleCycles(1);
        checkOutput("s2_chg_held", chg_req, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("s2_chg_drop", chg_req, 0);
        checkOutput("s2_credit_end", credit, 0);
        checkOutput("s2_idle", busy, 0);

        // Ceiling reject, then cancel refunds four 10s.
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("s3_credit_max", credit, 40);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("s3_reject", coin_reject, 1);
        checkOutput("s3_credit_kept", credit, 40);
        idleCycles(1);
        checkOutput("s3_reject_pulse", coin_reject, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("s3_cancel_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            idleCycles(1);
            checkOutput("s3_chg_req", chg_req, 1);
            checkOutput("s3_chg_coin", chg_coin, 1);
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
            checkOutput("s3_credit_step", credit, 30 - 10 * i);
        end
        checkOutput("s3_idle", busy, 0);

        // Deny, double coin, then timeout refund.
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkOutput("s4_deny", sel_deny, 1);
        checkOutput("s4_credit", credit, 10);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        checkOutput("s4_double_reject", coin_reject, 1);
        checkOutput("s4_double_credit", credit, 10);
        checkOutput("s4_deny_pulse", sel_deny, 0);
        idleCycles(TMO - 2);
        checkOutput("s4_before_timeout", busy, 0);
        idleCycles(1);
        checkOutput("s4_timeout", busy, 1);
        idleCycles(1);
        checkOutput("s4_refund_req", chg_req, 1);
        checkOutput("s4_refund_coin", chg_coin, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("s4_refund_credit", credit, 0);
        checkOutput("s4_idle", busy, 0);

        // Selection with a same-cycle coin, coin during dispense, reset mid-handshake.
        refill();
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("s5_credit", credit, 15);
        checkOutput("s5_disp_req", disp_req, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("s5_disp_reject", coin_reject, 1);
        checkOutput("s5_disp_credit", credit, 15);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkOutput("s5_disp_deny", sel_deny, 1);
        rst = 1'b1;
        #1;
        checkOutput("s5_rst_disp_req", disp_req, 0);
        checkOutput("s5_rst_credit", credit, 0);
        checkOutput("s5_rst_busy", busy, 0);
        checkOutput("s5_rst_deny", sel_deny, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("s5_stray_ack", busy, 0);
        checkOutput("s5_stray_chg", chg_req, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("s5_idle_deny", sel_deny, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkOutput("s5_b_disp_id", disp_id, 1);
        checkOutput("s5_b_credit", credit, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("s5_b_idle", busy, 0);

`ifdef VEND_STOCK_COUNT_EN
        // Stock limit of one per product.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("s6_disp_req", disp_req, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("s6_sold_out_a", sold_out[0], 1);
        checkOutput("s6_sold_out_b", sold_out[1], 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("s6_deny", sel_deny, 1);
        checkOutput("s6_credit", credit, 15);
        checkOutput("s6_no_disp", disp_req, 0);
        restock = 1'b1; restock_id = 1'b0;
        @(posedge clk); #1;
        restock = 1'b0;
        checkOutput("s6_restocked", sold_out[0], 0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Transaction controller for the coin-operated vending datapath: accumulates credit from 5- and 10-unit coin pulses and arbitrates product selection against price.
- Sequences the dispense mechanism through a req/ack handshake, then pays change one coin at a time through a second req/ack handshake.
- Sits between the coin acceptor and selection buttons on one side and the dispenser and change hopper on the other.

Parameters:
- PRICE_A, 15, price of product A (multiple of 5).
- PRICE_B, 20, price of product B (multiple of 5).
- MAX_CREDIT, 40, credit ceiling; a coin that would exceed it is rejected.
- CREDIT_W, 6, width of the credit register.
- TIMEOUT_CYC, 1000, idle cycles in CREDIT before automatic refund.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- coin_5  in  1  one-cycle pulse, 5-unit coin inserted.
- coin_10  in  1  one-cycle pulse, 10-unit coin inserted.
- sel_valid  in  1  one-cycle pulse, product selection.
- sel_id  in  1  0 = product A, 1 = product B.
- cancel  in  1  one-cycle pulse, refund request.
- disp_req  out  1  dispense request, held until ack.
- disp_id  out  1  product being dispensed, stable while disp_req = 1.
- disp_ack  in  1  dispenser done, one-cycle pulse.
- chg_req  out  1  change coin request, held until ack.
- chg_coin  out  1  0 = 5-unit coin, 1 = 10-unit coin; stable while chg_req = 1.
- chg_ack  in  1  hopper released one coin.
- credit  out  CREDIT_W  current credit.
- busy  out  1  high in DISPENSE and CHANGE.
- coin_reject  out  1  one-cycle pulse, coin not accepted (return path).
- sel_deny  out  1  one-cycle pulse, selection refused.

Behaviour:
- Reset (async, active-high): state IDLE, credit 0, timeout counter 0, all outputs 0. Reset mid-transaction abandons all credit and drops any pending req. No further handshake is issued.
- Coin acceptance:
  - Only in IDLE or CREDIT.
  - coin_5 and coin_10 asserted in the same cycle: both rejected.
  - A coin in DISPENSE or CHANGE is rejected.
  - A coin with credit + value > MAX_CREDIT is rejected.
  - Each rejection gives coin_reject for 1 cycle on the next edge; credit is unchanged.
  - An accepted coin updates credit on the next edge.
- IDLE: accepted coin -> CREDIT. sel_valid -> sel_deny. cancel is ignored.
- CREDIT:
  - Priority is cancel > sel_valid > timeout.
  - cancel: -> CHANGE; refund the full credit, including a coin accepted in the same cycle.
  - sel_valid with credit >= price(sel_id), evaluated on pre-coin credit:
    - credit_next = credit - price + accepted coin.
    - disp_id = sel_id; disp_req = 1 next cycle; -> DISPENSE.
  - sel_valid with credit < price: sel_deny pulse; stay in CREDIT; a same-cycle coin is still accepted.
  - Timeout counter clears on any accepted coin or selection. When it reaches TIMEOUT_CYC-1 -> CHANGE.
- DISPENSE: disp_req held until disp_ack; disp_req falls the edge after ack. Then credit == 0 -> IDLE, otherwise -> CHANGE.
- CHANGE:
  - chg_coin = 1 while credit >= 10, else 0.
  - chg_req held until chg_ack. On ack, credit -= 10 or 5 and chg_req deasserts for 1 cycle before the next coin.
  - credit reaches 0 -> IDLE.
- sel_valid and cancel in DISPENSE/CHANGE: sel_deny for sel_valid; cancel ignored.
- Arithmetic is unsigned, CREDIT_W bits. MAX_CREDIT must fit, so credit never wraps.
- Acks arriving without a matching req are ignored.

Optional Feature:
- Macro VEND_STOCK_COUNT_EN.
- When defined:
  - Adds parameter STOCK_INIT (default 8), inputs restock (pulse) and restock_id, and output sold_out[1:0].
  - Each product has a per-product 4-bit counter, loaded to STOCK_INIT on reset and on restock for that id.
  - Counter decrements on disp_ack; sold_out[i] = counter == 0.
  - Selecting a sold-out product gives sel_deny and no credit change.
- When undefined: stock is unlimited, sold_out is absent, and behaviour is exactly as above.

Test Plan:
- 5, 5, 5 then sel A -> credit 15, disp_req with disp_id 0; after disp_ack: credit 0, IDLE, no chg_req.
- 10, 10 then sel A -> disp_req; after ack, chg_req with chg_coin 0 once; after chg_ack: credit 0, IDLE.
- 10, 10, 10, 10 then a 5 -> coin_reject, credit 40. Cancel -> four chg_req with chg_coin 1, each acked; credit 0.
- Credit 10, sel B -> sel_deny, credit 10. coin_5 and coin_10 in the same cycle -> coin_reject, credit 10. No activity for TIMEOUT_CYC cycles -> one 10-unit refund.
- Credit 20, sel A with coin_10 in the same cycle -> credit 15, disp_req. A coin during DISPENSE -> coin_reject. Assert rst while disp_req = 1 -> all outputs 0 immediately.
- VEND_STOCK_COUNT_EN with STOCK_INIT 1 -> first sale of A succeeds and sold_out[0] = 1; second sel A -> sel_deny. restock A -> sold_out[0] = 0.
